integral_row_engine: RTL and testbench
======================================

# integral_row_engine

Streaming integral-image generator for the face-detection front end. It accepts one pixel per handshake and emits the integral value ii(x,y) = ii(x,y-1) + rowsum(x) for every pixel. It also provides a sliding window of the last WIN_W integral values of the current row for the Haar feature taps. It replaces the fixed-depth FIFO row with a runtime-configurable line buffer, frame control, and full valid/ready flow control, and sits between the pixel capture stage and the Haar window evaluator.

## Interface
- PIX_WIDTH, 8, pixel width
- SUM_WIDTH, 20, integral value width; all arithmetic modulo 2^SUM_WIDTH
- MAX_COLS, 640, line-buffer depth (maximum image width)
- COL_WIDTH, 10, column/config counter width; must satisfy 2^COL_WIDTH ≥ MAX_COLS
- ROW_WIDTH, 10, row counter width
- WIN_W, 3, number of window taps on o_window
- clk_os  in  1  single clock, all logic rising-edge
- reset_os  in  1  asynchronous, active-low reset
- i_cfg_cols  in  COL_WIDTH  image width; sampled on accepted SOF pixel
- i_cfg_rows  in  ROW_WIDTH  image height; sampled on accepted SOF pixel
- i_valid  in  1  input pixel valid
- i_sof  in  1  marks the first pixel of a frame; qualified by i_valid
- i_pixel  in  PIX_WIDTH  pixel value
- o_ready  out  1  engine can accept a pixel this cycle
- o_valid  out  1  o_sum, o_window, o_col, o_row, o_eol, o_eof are valid
- i_ready  in  1  downstream accepts the output this cycle
- o_sum  out  SUM_WIDTH  ii(col,row)
- o_window  out  WIN_W*SUM_WIDTH  tap k (bits k*SUM_WIDTH upward) = ii(col-k,row), 0 when col-k<0
- o_col, o_row  out  COL_WIDTH, ROW_WIDTH  coordinates of o_sum
- o_eol, o_eof  out  1  last column of a row / last pixel of a frame
- o_err  out  1  one-cycle pulse on a protocol error

## Operation
- **Input accept:** a pixel is accepted when i_valid && o_ready.
- **States:**
  - IDLE (after reset and after each frame end): accepted pixels without i_sof are dropped and pulse o_err. An accepted pixel with i_sof latches cfg, sets col=0, row=0, processes the pixel, and moves to RUN.
  - RUN: each accepted pixel increments col. At col==cols-1, col wraps to 0 and row increments; the row accumulator clears.
  - At col==cols-1 and row==rows-1, the pixel is tagged eof and the state returns to IDLE.
- **Config clamping:** cfg value 0 or >MAX_COLS clamps to MAX_COLS. i_cfg_rows of 0 clamps to 2^ROW_WIDTH-1.
- **SOF mid-frame (RUN):** pulse o_err and restart exactly as from IDLE. The SOF pixel itself is processed as (0,0).
- **Integral computation:** rowsum += pixel. The previous-row value is read from the line buffer at col and is forced to 0 when row==0. The RAM is not cleared, so stale contents must never leak. The new ii value is written back to the same address, read-before-write.
- **Window taps:** shift on every processed pixel and clear at col==0 before loading tap 0.
- **Arithmetic:** unsigned, wraps modulo 2^SUM_WIDTH with no saturation. Pixels are zero-extended.
- **Line buffer:** single-port synchronous RAM, MAX_COLS × SUM_WIDTH.

## Timing
- Two-stage pipeline:
  - S1: accept, RAM read, rowsum update.
  - S2: add, RAM write, output register.
- Latency from acceptance to o_valid: 2 cycles. Throughput: 1 pixel/cycle with i_ready high.
- **Stall:** when o_valid && !i_ready, the whole pipeline freezes.
  - o_ready = !(S2 full && !i_ready), combinational.
  - Outputs are held stable while stalled, and no pixel is lost or duplicated.
- **RAM hazard:** a read at col must see the write issued for the same col one row earlier. With cols==1, the write and the next read are back-to-back; the write result is forwarded.
- **Reset:** reset_os low asynchronously clears all state.
  - o_valid=0, o_sum=0, o_window=0, o_col=0, o_row=0, o_eol=0, o_eof=0, o_err=0. State is IDLE.
  - o_ready=1 from the first edge after release.
  - Reset mid-frame discards in-flight pixels.
- **o_err:** asserted for exactly one cycle, registered, independent of i_ready.

## Test plan
- **3×3 frame of ones, continuous:** o_sum = 1,2,3,2,4,6,3,6,9; o_eol on cols 2; o_eof only with 9; first o_valid 2 cycles after the first accept.
- **Backpressure:** 4×2 ones with i_ready low for 5 cycles after the 3rd output. o_sum holds at 3 and o_ready goes low. The output stream is 1,2,3,4,2,4,6,8 with no gaps or duplicates.
- **Wrap, SUM_WIDTH=12:** 5×4 frame of 255. Final o_sum = 5100 mod 4096 = 1004 with o_eof=1.
- **Window taps, WIN_W=3:** cols=4, row 0 pixels 1,1,1,1. At col 3, o_window = {4,3,2} for taps 0,1,2. At col 0 of row 1 (pixel 1), taps = {2,0,0}.
- **SOF mid-frame:** 3×3 frame, sof reasserted on the 5th pixel (value 7). o_err pulses once, o_row=0, o_col=0, o_sum=7, and no previous-row contribution appears.
- **Reset mid-row:** pull reset_os low for 1 cycle. All outputs read 0 immediately. Non-SOF pixels afterwards are dropped with o_err pulses; a following SOF frame produces the correct sums.

Source files
------------

// File: rtl/integral_row_engine.sv
// Streaming integral-image engine: one pixel in, one ii(x,y) out, with a
// runtime-sized line buffer holding the previous row and a WIN_W-tap window.
module integral_row_engine #(
  parameter int PIX_WIDTH = 8,
  parameter int SUM_WIDTH = 20,
  parameter int MAX_COLS  = 640,
  parameter int COL_WIDTH = 10,
  parameter int ROW_WIDTH = 10,
  parameter int WIN_W     = 3
) (
  input  logic                       clk_os,
  input  logic                       reset_os,
  input  logic [COL_WIDTH-1:0]       i_cfg_cols,
  input  logic [ROW_WIDTH-1:0]       i_cfg_rows,
  input  logic                       i_valid,
  input  logic                       i_sof,
  input  logic [PIX_WIDTH-1:0]       i_pixel,
  output logic                       o_ready,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [SUM_WIDTH-1:0]       o_sum,
  output logic [WIN_W*SUM_WIDTH-1:0] o_window,
  output logic [COL_WIDTH-1:0]       o_col,
  output logic [ROW_WIDTH-1:0]       o_row,
  output logic                       o_eol,
  output logic                       o_eof,
  output logic                       o_err
);

  localparam int ADDR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [COL_WIDTH-1:0] MAX_COLS_C = COL_WIDTH'(MAX_COLS);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [COL_WIDTH-1:0] col_q, cfg_cols_q;
  logic [ROW_WIDTH-1:0] row_q, cfg_rows_q;
  logic [SUM_WIDTH-1:0] rowsum_q;

  logic                 advance, accept, process, err_d, eol, eof;
  logic [COL_WIDTH-1:0] cols_clamped, cur_col, cur_cols;
  logic [ROW_WIDTH-1:0] rows_clamped, cur_row, cur_rows;
  logic [SUM_WIDTH-1:0] rowsum_base, rowsum_cur;

  logic                 s1_valid, s1_eol, s1_eof;
  logic [COL_WIDTH-1:0] s1_col;
  logic [ROW_WIDTH-1:0] s1_row;
  logic [SUM_WIDTH-1:0] s1_rowsum;

  logic [SUM_WIDTH-1:0] mem [MAX_COLS];
  logic [SUM_WIDTH-1:0] ram_q, fwd_val_q, prev_ii, new_ii;
  logic                 fwd_q;
  logic [SUM_WIDTH-1:0] win_q [WIN_W];

  assign o_ready = !(o_valid && !i_ready);

  // An SOF pixel restarts the frame at (0,0) with freshly clamped geometry.
  always_comb begin
    advance      = !(o_valid && !i_ready);
    accept       = i_valid && advance;
    cols_clamped = (i_cfg_cols == '0 || i_cfg_cols > MAX_COLS_C) ? MAX_COLS_C : i_cfg_cols;
    rows_clamped = (i_cfg_rows == '0) ? '1 : i_cfg_rows;
    cur_col      = col_q;
    cur_row      = row_q;
    cur_cols     = cfg_cols_q;
    cur_rows     = cfg_rows_q;
    if (i_sof) begin
      cur_col  = '0;
      cur_row  = '0;
      cur_cols = cols_clamped;
      cur_rows = rows_clamped;
    end
    rowsum_base = (cur_col == '0) ? '0 : rowsum_q;
    rowsum_cur  = rowsum_base + {{(SUM_WIDTH-PIX_WIDTH){1'b0}}, i_pixel};
    eol         = (cur_col == cur_cols - COL_WIDTH'(1));
    eof         = eol && (cur_row == cur_rows - ROW_WIDTH'(1));
    process     = accept && (i_sof || state_q == RUN);
    err_d       = accept && (i_sof ? (state_q == RUN) : (state_q == IDLE));
    state_d     = state_q;
    if (process) state_d = eof ? IDLE : RUN;
  end

  always_ff @(posedge clk_os or negedge reset_os) begin
    if (!reset_os) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_os or negedge reset_os) begin
    if (!reset_os) begin
      col_q      <= '0;
      row_q      <= '0;
      cfg_cols_q <= '0;
      cfg_rows_q <= '0;
      rowsum_q   <= '0;
      o_err      <= 1'b0;
    end else begin
      o_err <= err_d;
      if (process) begin
        col_q      <= eol ? '0 : cur_col + COL_WIDTH'(1);
        row_q      <= eol ? cur_row + ROW_WIDTH'(1) : cur_row;
        cfg_cols_q <= cur_cols;
        cfg_rows_q <= cur_rows;
        rowsum_q   <= rowsum_cur;
      end
    end
  end

  // Row 0 never reads the line buffer, so stale contents cannot leak in;
  // a same-address write one cycle earlier (cols==1) is forwarded.
  always_comb begin
    prev_ii = '0;
    if (s1_row != '0) prev_ii = fwd_q ? fwd_val_q : ram_q;
    new_ii = s1_rowsum + prev_ii;
  end

  always_ff @(posedge clk_os) begin
    if (process)             ram_q <= mem[cur_col[ADDR_W-1:0]];
    if (advance && s1_valid) mem[s1_col[ADDR_W-1:0]] <= new_ii;
  end

  always_ff @(posedge clk_os or negedge reset_os) begin
    if (!reset_os) begin
      s1_valid  <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_rowsum <= '0;
      s1_eol    <= 1'b0;
      s1_eof    <= 1'b0;
      fwd_q     <= 1'b0;
      fwd_val_q <= '0;
    end else if (advance) begin
      s1_valid  <= process;
      fwd_q     <= process && s1_valid && (s1_col == cur_col);
      fwd_val_q <= new_ii;
      if (process) begin
        s1_col    <= cur_col;
        s1_row    <= cur_row;
        s1_rowsum <= rowsum_cur;
        s1_eol    <= eol;
        s1_eof    <= eof;
      end
    end
  end

  always_ff @(posedge clk_os or negedge reset_os) begin
    if (!reset_os) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_col   <= '0;
      o_row   <= '0;
      o_eol   <= 1'b0;
      o_eof   <= 1'b0;
      for (int k = 0; k < WIN_W; k++) win_q[k] <= '0;
    end else if (advance) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_sum <= new_ii;
        o_col <= s1_col;
        o_row <= s1_row;
        o_eol <= s1_eol;
        o_eof <= s1_eof;
        for (int k = 1; k < WIN_W; k++) win_q[k] <= (s1_col == '0) ? '0 : win_q[k-1];
        win_q[0] <= new_ii;
      end
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < WIN_W; k++) o_window[k*SUM_WIDTH +: SUM_WIDTH] = win_q[k];
  end

endmodule

// File: tb/tb_integral_row_engine.sv
// Scoreboarded bench for integral_row_engine: ii values are computed from the
// stored frame by direct double summation, with random backpressure and gaps.
module tb_integral_row_engine;

  localparam int PW   = 8;
  localparam int SW   = 12;
  localparam int MAXC = 16;
  localparam int CW   = 5;
  localparam int RW   = 4;
  localparam int WW   = 3;

  logic             clk_os = 1'b0;
  logic             reset_os = 1'b0;
  logic [CW-1:0]    i_cfg_cols = '0;
  logic [RW-1:0]    i_cfg_rows = '0;
  logic             i_valid = 1'b0;
  logic             i_sof = 1'b0;
  logic [PW-1:0]    i_pixel = '0;
  logic             o_ready;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [SW-1:0]    o_sum;
  logic [WW*SW-1:0] o_window;
  logic [CW-1:0]    o_col;
  logic [RW-1:0]    o_row;
  logic             o_eol;
  logic             o_eof;
  logic             o_err;

  integral_row_engine #(
    .PIX_WIDTH(PW), .SUM_WIDTH(SW), .MAX_COLS(MAXC),
    .COL_WIDTH(CW), .ROW_WIDTH(RW), .WIN_W(WW)
  ) dut (
    .clk_os(clk_os), .reset_os(reset_os),
    .i_cfg_cols(i_cfg_cols), .i_cfg_rows(i_cfg_rows),
    .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_window(o_window), .o_col(o_col), .o_row(o_row),
    .o_eol(o_eol), .o_eof(o_eof), .o_err(o_err)
  );

  initial forever #5 clk_os = ~clk_os;

  typedef struct {
    logic [SW-1:0]    sum;
    logic [WW*SW-1:0] win;
    int               col;
    int               row;
    bit               eol;
    bit               eof;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   err_exp[int];
  int   img[int];
  bit   m_run = 0;
  int   m_cols = 0, m_rows = 0, m_col = 0, m_row = 0;
  int   ready_prob = 100;
  int   stall_after = -1;
  int   stall_cnt = 0;
  int   out_count = 0;
  int   stall3_cycles = 0;
  bit   lat_en = 0;
  logic [SW-1:0] last_eof_sum = '0;

  function automatic void check(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ii(x,y) straight from its definition: sum of all pixels above-left inclusive.
  function automatic longint ii(int x, int y);
    longint s = 0;
    for (int r = 0; r <= y; r++)
      for (int c = 0; c <= x; c++)
        if (img.exists(r*1024 + c)) s += img[r*1024 + c];
    return s & ((64'd1 << SW) - 1);
  endfunction

  function automatic void model_accept(int pix, bit sof, int cfgc, int cfgr);
    exp_t e;
    if (sof) begin
      if (m_run) err_exp[cyc+1] = 1'b1;
      m_run  = 1'b1;
      m_cols = (cfgc == 0 || cfgc > MAXC) ? MAXC : cfgc;
      m_rows = (cfgr == 0) ? ((1 << RW) - 1) : cfgr;
      m_col  = 0;
      m_row  = 0;
      img.delete();
    end else if (!m_run) begin
      err_exp[cyc+1] = 1'b1;
      return;
    end
    img[m_row*1024 + m_col] = pix;
    e.sum = SW'(ii(m_col, m_row));
    e.win = '0;
    for (int k = 0; k < WW; k++)
      if (m_col - k >= 0) e.win[k*SW +: SW] = SW'(ii(m_col - k, m_row));
    e.col = m_col;
    e.row = m_row;
    e.eol = (m_col == m_cols - 1);
    e.eof = e.eol && (m_row == m_rows - 1);
    e.acc = cyc;
    e.lat = lat_en;
    sbq.push_back(e);
    if (e.eol) begin
      m_col = 0;
      m_row++;
      if (e.eof) m_run = 1'b0;
    end else begin
      m_col++;
    end
  endfunction

  initial forever begin
    @(posedge clk_os);
    cyc++;
  end

  // Downstream readiness: random, with an optional directed 5-cycle stall.
  initial forever begin
    @(negedge clk_os);
    if (stall_cnt > 0) begin
      i_ready = 1'b0;
      stall_cnt--;
    end else if (stall_after >= 0 && out_count == stall_after && o_valid) begin
      i_ready     = 1'b0;
      stall_cnt   = 4;
      stall_after = -1;
    end else begin
      i_ready = ($urandom_range(99) < 32'(ready_prob));
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t             e;
    bit               prev_stall = 0;
    logic [SW-1:0]    p_sum = '0;
    logic [WW*SW-1:0] p_win = '0;
    logic [CW-1:0]    p_col = '0;
    logic [RW-1:0]    p_row = '0;
    forever begin
      @(negedge clk_os);
      #3;
      if (reset_os) begin
        check("o_err", longint'(o_err), err_exp.exists(cyc) ? 1 : 0);
        check("o_ready", longint'(o_ready), (o_valid && !i_ready) ? 0 : 1);
        if (prev_stall) begin
          check("stall o_valid", longint'(o_valid), 1);
          check("stall o_sum", longint'(o_sum), longint'(p_sum));
          check("stall o_window", longint'(o_window), longint'(p_win));
          check("stall o_col", longint'(o_col), longint'(p_col));
          check("stall o_row", longint'(o_row), longint'(p_row));
        end
        if (o_valid && !i_ready && o_sum == SW'(3)) stall3_cycles++;
        if (o_valid && i_ready) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected output: got sum %0d expected no output", o_sum);
          end else begin
            e = sbq.pop_front();
            check("o_sum", longint'(o_sum), longint'(e.sum));
            check("o_window", longint'(o_window), longint'(e.win));
            check("o_col", longint'(o_col), longint'(e.col));
            check("o_row", longint'(o_row), longint'(e.row));
            check("o_eol", longint'(o_eol), longint'(e.eol));
            check("o_eof", longint'(o_eof), longint'(e.eof));
            if (e.lat) check("latency", longint'(cyc - e.acc), 2);
            out_count++;
            if (o_eof) last_eof_sum = o_sum;
          end
        end
        prev_stall = o_valid && !i_ready;
        p_sum = o_sum;
        p_win = o_window;
        p_col = o_col;
        p_row = o_row;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input int pix, input bit sof, input int cfgc, input int cfgr);
    int waited = 0;
    @(negedge clk_os);
    i_valid    = 1'b1;
    i_sof      = sof;
    i_pixel    = PW'(pix);
    i_cfg_cols = CW'(cfgc);
    i_cfg_rows = RW'(cfgr);
    #2;
    while (!o_ready && waited < 50) begin
      @(negedge clk_os);
      #2;
      waited++;
    end
    if (!o_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept timeout: o_ready got 0 expected 1");
    end else begin
      model_accept(pix, sof, cfgc, cfgr);
    end
    @(posedge clk_os);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic send_frame(input int n, input int cfgc, input int cfgr,
                            input int val, input bit rnd, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && $urandom_range(99) < 32'(gap)) @(negedge clk_os);
      applyStimulus(rnd ? int'($urandom_range(255)) : val, i == 0, cfgc, cfgr);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 1000) begin
      @(negedge clk_os);
      t++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending outputs expected 0", sbq.size());
      sbq.delete();
    end
    repeat (3) @(negedge clk_os);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " o_valid"}, longint'(o_valid), 0);
    check({tag, " o_sum"}, longint'(o_sum), 0);
    check({tag, " o_window"}, longint'(o_window), 0);
    check({tag, " o_col"}, longint'(o_col), 0);
    check({tag, " o_row"}, longint'(o_row), 0);
    check({tag, " o_eol"}, longint'(o_eol), 0);
    check({tag, " o_eof"}, longint'(o_eof), 0);
    check({tag, " o_err"}, longint'(o_err), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_os);
    reset_os = 1'b0;
    #1;
    checkOutput("reset");
    sbq.delete();
    err_exp.delete();
    m_run = 1'b0;
    @(negedge clk_os);
    reset_os = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk_os);
    #1;
    checkOutput("power-on reset");
    @(negedge clk_os);
    reset_os = 1'b1;
    @(negedge clk_os);
    #1;
    check("o_ready after reset", longint'(o_ready), 1);

    $display("[TB] 3x3 ones, continuous");
    lat_en = 1'b1;
    send_frame(9, 3, 3, 1, 0, 0);
    drain();
    lat_en = 1'b0;

    $display("[TB] 4x2 ones with 5-cycle backpressure");
    out_count     = 0;
    stall3_cycles = 0;
    stall_after   = 2;
    send_frame(8, 4, 2, 1, 0, 0);
    drain();
    check("stall cycles holding 3", longint'(stall3_cycles), 5);

    $display("[TB] 5x4 frame of 255, wrap");
    send_frame(20, 5, 4, 255, 0, 0);
    drain();
    check("wrap final sum", longint'(last_eof_sum), 1004);

    $display("[TB] window taps, 4x2 ones");
    send_frame(8, 4, 2, 1, 0, 0);
    drain();

    $display("[TB] SOF mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(1, i == 0, 3, 3);
    applyStimulus(7, 1, 3, 3);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 3, 3);
    drain();

    $display("[TB] reset mid-row");
    for (int i = 0; i < 5; i++) applyStimulus(int'($urandom_range(255)), i == 0, 4, 3);
    pulse_reset();
    for (int i = 0; i < 3; i++) applyStimulus(5, 0, 3, 2);
    send_frame(6, 3, 2, 0, 1, 0);
    drain();

    $display("[TB] config clamping and single-column forwarding");
    send_frame(16, 0, 1, 1, 0, 0);
    send_frame(16, 20, 1, 0, 1, 0);
    send_frame(15, 1, 0, 0, 1, 0);
    send_frame(5, 1, 5, 0, 1, 0);
    drain();

    $display("[TB] random frames with backpressure");
    ready_prob = 60;
    for (int f = 0; f < 40; f++) begin
      int c, r, n;
      c = int'($urandom_range(8, 1));
      r = int'($urandom_range(4, 1));
      n = ($urandom_range(3) == 0) ? int'($urandom_range(c*r, 1)) : c*r;
      if ($urandom_range(7) == 0) applyStimulus(int'($urandom_range(255)), 0, c, r);
      send_frame(n, c, r, 0, 1, 20);
    end
    ready_prob = 100;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
